// File: rtl/mult_unit_if.sv
// Execute-stage MULT handshake: operands and control from X, product and
// pipeline hold back to the core.
interface mult_unit_if #(
  parameter int DATA_W = 32
);
  logic              start_X;
  logic              flush_X;
  logic [DATA_W-1:0] rs_data_X;
  logic [DATA_W-1:0] rt_data_X;
  logic [4:0]        rd_X;
  logic              stall_req;
  logic              busy;
  logic              done;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start_X, flush_X, rs_data_X, rt_data_X, rd_X,
    input  stall_req, busy, done, wb_rd, hi, lo
  );

  modport slave (
    input  start_X, flush_X, rs_data_X, rt_data_X, rd_X,
    output stall_req, busy, done, wb_rd, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative signed DATA_W x DATA_W multiplier for the execute stage.
// Works on operand magnitudes with a radix-2 shift-add loop, then applies
// the sign to the full 2*DATA_W product and writes it into HI/LO.
module mult_unit #(
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mult_unit_if.slave     mif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic                neg_q, neg_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [2*DATA_W-1:0] sum;
  logic [2*DATA_W-1:0] prod;
  logic                start_ok;

  // Operand magnitudes, the current shift-add step and the signed final product.
  always_comb begin
    rs_mag   = mif.rs_data_X[DATA_W-1] ? -mif.rs_data_X : mif.rs_data_X;
    rt_mag   = mif.rt_data_X[DATA_W-1] ? -mif.rt_data_X : mif.rt_data_X;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod     = neg_q ? -sum : sum;
    start_ok = mif.start_X & ~mif.flush_X;
  end

  // Next-state logic: capture on start, step in RUN, publish on the last step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    wb_rd_d  = wb_rd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          mcand_d  = {{DATA_W{1'b0}}, rs_mag};
          mplier_d = rt_mag;
          neg_d    = mif.rs_data_X[DATA_W-1] ^ mif.rt_data_X[DATA_W-1];
          rd_d     = mif.rd_X;
          acc_d    = '0;
          cnt_d    = CNT_W'(DATA_W);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mif.flush_X) begin
          state_d = IDLE;
        end else begin
          acc_d    = sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            {hi_d, lo_d} = prod;
            wb_rd_d      = rd_q;
            state_d      = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      wb_rd_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      wb_rd_q  <= wb_rd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Status decoded from the state register; stall also covers the start cycle.
  always_comb begin
    mif.busy      = (state_q == RUN);
    mif.done      = (state_q == DONE);
    mif.stall_req = ((state_q == IDLE) & start_ok) | (state_q == RUN);
    mif.wb_rd     = wb_rd_q;
    mif.hi        = hi_q;
    mif.lo        = lo_q;
  end

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: reset, basic/signed products, flush,
// asynchronous reset mid-run and back-to-back MULTs.
module tb_mult_unit;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  time  done_t;

  mult_unit_if #(.DATA_W(DATA_W)) mif ();

  mult_unit #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  always #5 clk = ~clk;

  // Issue one MULT at the current negedge and follow it to its done pulse.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          output int done_cyc, output int hs_bad, output logic stall_at_done,
                          output logic [31:0] hi_o, output logic [31:0] lo_o, output logic [4:0] rd_o);
    mif.start_X   = 1'b1;
    mif.flush_X   = 1'b0;
    mif.rs_data_X = a;
    mif.rt_data_X = b;
    mif.rd_X      = rd;
    done_cyc      = -1;
    hs_bad        = 0;
    stall_at_done = 1'b1;
    hi_o          = 'x;
    lo_o          = 'x;
    rd_o          = 'x;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mif.done === 1'b1) begin
        done_cyc      = c;
        done_t        = $time;
        stall_at_done = mif.stall_req;
        hi_o          = mif.hi;
        lo_o          = mif.lo;
        rd_o          = mif.wb_rd;
        break;
      end
      if (mif.stall_req !== 1'b1 || mif.busy !== (c != 0)) hs_bad++;
      @(negedge clk);
    end
    @(negedge clk);
    mif.start_X = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    mif.start_X   = 1'b0;
    mif.flush_X   = 1'b0;
    mif.rs_data_X = '0;
    mif.rt_data_X = '0;
    mif.rd_X      = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({mif.busy, mif.done, mif.stall_req} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got %b expected 000", {mif.busy, mif.done, mif.stall_req});
    end
    vectors++;
    if ({mif.hi, mif.lo, mif.wb_rd} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs: got hi=%h lo=%h rd=%0d expected 0", mif.hi, mif.lo, mif.wb_rd);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, hb;
    logic sd;
    logic [31:0] h, l;
    logic [4:0] r;
    run_mult(32'd7, 32'd6, 5'd5, dc, hb, sd, h, l, r);
    vectors++;
    if (dc !== 33) begin
      miscompares++;
      $display("[TB] FAIL basic_done_cycle: got %0d expected 33", dc);
    end
    vectors++;
    if (hb !== 0) begin
      miscompares++;
      $display("[TB] FAIL basic_stall_busy: got %0d bad cycles expected 0", hb);
    end
    vectors++;
    if (sd !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_stall_at_done: got %b expected 0", sd);
    end
    vectors++;
    if ({h, l} !== 64'h0000_0000_0000_002A) begin
      miscompares++;
      $display("[TB] FAIL basic_product: got %h_%h expected 00000000_0000002a", h, l);
    end
    vectors++;
    if (r !== 5'd5) begin
      miscompares++;
      $display("[TB] FAIL basic_wb_rd: got %0d expected 5", r);
    end
    vectors++;
    #1;
    if ({mif.done, mif.busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL basic_after_done: got done,busy=%b expected 00", {mif.done, mif.busy});
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [31:0] ta [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] tb [4] = '{32'd5,         32'h8000_0000, 32'd1,         32'hFFFF_FFFE};
    logic [63:0] te [4] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h4000_0000_0000_0000,
                            64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0002};
    int dc, hb;
    logic sd;
    logic [31:0] h, l;
    logic [4:0] r;
    for (int i = 0; i < 4; i++) begin
      run_mult(ta[i], tb[i], 5'(i + 10), dc, hb, sd, h, l, r);
      vectors++;
      if ({h, l} !== te[i] || dc !== 33) begin
        miscompares++;
        $display("[TB] FAIL signed_%0d: got %h_%h at cycle %0d expected %h at cycle 33", i, h, l, dc, te[i]);
      end
      vectors++;
      if (r !== 5'(i + 10)) begin
        miscompares++;
        $display("[TB] FAIL signed_rd_%0d: got %0d expected %0d", i, r, i + 10);
      end
    end
  endtask

  task automatic test_flush();
    int dc, hb, dones;
    logic sd;
    logic [31:0] h, l;
    logic [4:0] r;
    run_mult(32'd2, 32'd3, 5'd7, dc, hb, sd, h, l, r);
    vectors++;
    if (l !== 32'd6 || dc !== 33) begin
      miscompares++;
      $display("[TB] FAIL flush_preload: got lo=%h cycle %0d expected 6 cycle 33", l, dc);
    end
    mif.start_X   = 1'b1;
    mif.rs_data_X = 32'd9;
    mif.rt_data_X = 32'd9;
    mif.rd_X      = 5'd9;
    repeat (10) @(negedge clk);
    mif.flush_X = 1'b1;
    #1;
    vectors++;
    if ({mif.busy, mif.stall_req} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL flush_cycle10: got busy,stall=%b expected 11", {mif.busy, mif.stall_req});
    end
    @(negedge clk);
    mif.flush_X = 1'b0;
    mif.start_X = 1'b0;
    #1;
    vectors++;
    if ({mif.busy, mif.stall_req, mif.done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL flush_cycle11: got busy,stall,done=%b expected 000", {mif.busy, mif.stall_req, mif.done});
    end
    vectors++;
    if ({mif.hi, mif.lo, mif.wb_rd} !== {32'd0, 32'd6, 5'd7}) begin
      miscompares++;
      $display("[TB] FAIL flush_hold: got hi=%h lo=%h rd=%0d expected 0/6/7", mif.hi, mif.lo, mif.wb_rd);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (mif.done === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("[TB] FAIL flush_no_done: got %0d done pulses expected 0", dones);
    end
    // Flush in the same cycle as a start wins over the start.
    @(negedge clk);
    mif.start_X = 1'b1;
    mif.flush_X = 1'b1;
    #1;
    vectors++;
    if (mif.stall_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_same_cycle_stall: got %b expected 0", mif.stall_req);
    end
    @(negedge clk);
    mif.start_X = 1'b0;
    mif.flush_X = 1'b0;
    #1;
    vectors++;
    if (mif.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_same_cycle_busy: got %b expected 0", mif.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int dc, hb;
    logic sd;
    logic [31:0] h, l;
    logic [4:0] r;
    mif.start_X   = 1'b1;
    mif.rs_data_X = 32'd9;
    mif.rt_data_X = 32'd9;
    mif.rd_X      = 5'd3;
    repeat (15) @(negedge clk);
    mif.start_X = 1'b0;
    #2;
    vectors++;
    if (mif.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL areset_pre_busy: got %b expected 1", mif.busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({mif.busy, mif.stall_req, mif.done} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL areset_status: got busy,stall,done=%b expected 000", {mif.busy, mif.stall_req, mif.done});
    end
    vectors++;
    if ({mif.hi, mif.lo} !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL areset_hilo: got %h_%h expected 0", mif.hi, mif.lo);
    end
    @(negedge clk);
    rst = 1'b1;
    run_mult(32'd4, 32'd4, 5'd2, dc, hb, sd, h, l, r);
    vectors++;
    if ({h, l} !== 64'd16 || dc !== 33 || hb !== 0) begin
      miscompares++;
      $display("[TB] FAIL areset_after: got %h_%h cycle %0d bad %0d expected 16 cycle 33", h, l, dc, hb);
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2, hb;
    logic sd;
    logic [31:0] h, l1, l2, h2;
    logic [4:0] r;
    time t1;
    run_mult(32'd2, 32'd2, 5'd3, dc1, hb, sd, h, l1, r);
    t1 = done_t;
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, dc2, hb, sd, h2, l2, r);
    vectors++;
    if ({h, l1} !== 64'd4 || dc1 !== 33) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got %h_%h cycle %0d expected 4 cycle 33", h, l1, dc1);
    end
    vectors++;
    if ({h2, l2} !== 64'd1 || dc2 !== 33 || r !== 5'd4) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got %h_%h cycle %0d rd %0d expected 1 cycle 33 rd 4", h2, l2, dc2, r);
    end
    vectors++;
    if (done_t - t1 !== 340) begin
      miscompares++;
      $display("[TB] FAIL b2b_spacing: got %0t expected 340", done_t - t1);
    end
  endtask

  // Global time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
